// File: rtl/as_gpio_ctrl.sv
// as_gpio_ctrl: memory-mapped GPIO with per-pin direction, synchronised inputs and
// an edge/level interrupt unit with write-1-to-clear status and one combined irq.
module as_gpio_ctrl #(
  parameter int NR_GPIOS    = 8,
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ID_VALUE    = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  // Handshake: sel_i is a one-cycle request with no back-pressure; every request is
  // answered by ack_o exactly one cycle later, and rdata_o is valid only while ack_o = 1.
  input  logic                  sel_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  ack_o,
  input  logic [NR_GPIOS-1:0]   gpio_i,
  output logic [NR_GPIOS-1:0]   gpio_o,
  output logic [NR_GPIOS-1:0]   gpio_oe_o,
  output logic                  irq_o
);

  localparam logic [ADDR_WIDTH-1:0] IDX_ID    = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] IDX_DIR   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] IDX_DOUT  = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] IDX_DIN   = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] IDX_SENSE = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] IDX_EVENT = ADDR_WIDTH'(5);
  localparam logic [ADDR_WIDTH-1:0] IDX_BOTH  = ADDR_WIDTH'(6);
  localparam logic [ADDR_WIDTH-1:0] IDX_IMSC  = ADDR_WIDTH'(7);
  localparam logic [ADDR_WIDTH-1:0] IDX_RIS   = ADDR_WIDTH'(8);
  localparam logic [ADDR_WIDTH-1:0] IDX_MIS   = ADDR_WIDTH'(9);
  localparam logic [ADDR_WIDTH-1:0] IDX_ICR   = ADDR_WIDTH'(10);

  logic [NR_GPIOS-1:0] dir_q, dout_q, sense_q, event_q, both_q, imsc_q;
  logic [NR_GPIOS-1:0] sync_q [SYNC_STAGES];
  logic [NR_GPIOS-1:0] prev_q, sticky_q;
  logic [NR_GPIOS-1:0] din, rise, fall, edge_hit, level_hit, ris, mis, icr_clr;
  logic [NR_GPIOS-1:0] wdata_pins, rd_pins;
  logic [DATA_WIDTH-1:0] rd_word, rdata_q;
  logic                wr_en, id_hit, ack_q, irq_q;
  logic                unused_wdata;

  assign wr_en        = sel_i & we_i;
  assign wdata_pins   = wdata_i[NR_GPIOS-1:0];
  assign unused_wdata = ^(wdata_i >> NR_GPIOS);

  // Configuration and output registers; RO and unmapped indices ignore writes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dir_q   <= '0;
      dout_q  <= '0;
      sense_q <= '0;
      event_q <= '0;
      both_q  <= '0;
      imsc_q  <= '0;
    end else if (wr_en) begin
      case (addr_i)
        IDX_DIR:   dir_q   <= wdata_pins;
        IDX_DOUT:  dout_q  <= wdata_pins;
        IDX_SENSE: sense_q <= wdata_pins;
        IDX_EVENT: event_q <= wdata_pins;
        IDX_BOTH:  both_q  <= wdata_pins;
        IDX_IMSC:  imsc_q  <= wdata_pins;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= gpio_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign din  = sync_q[SYNC_STAGES-1];
  assign rise = din & ~prev_q;
  assign fall = ~din & prev_q;

  // BOTH overrides EVENT for edge pins; level pins never touch the sticky bit.
  assign edge_hit  = ~sense_q & ((both_q & (rise | fall)) |
                                 (~both_q & ((event_q & rise) | (~event_q & fall))));
  assign level_hit = (event_q & din) | (~event_q & ~din);
  assign icr_clr   = (wr_en && addr_i == IDX_ICR) ? wdata_pins : '0;

  // A set in the same cycle as a clear wins, so no edge is ever lost to a racing ICR write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sticky_q <= '0;
    else         sticky_q <= (sticky_q & ~icr_clr) | edge_hit;
  end

  assign ris = (sense_q & level_hit) | (~sense_q & sticky_q);
  assign mis = ris & imsc_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) irq_q <= 1'b0;
    else         irq_q <= |mis;
  end

  always_comb begin
    rd_pins = '0;
    id_hit  = 1'b0;
    case (addr_i)
      IDX_ID:    id_hit  = 1'b1;
      IDX_DIR:   rd_pins = dir_q;
      IDX_DOUT:  rd_pins = dout_q;
      IDX_DIN:   rd_pins = din;
      IDX_SENSE: rd_pins = sense_q;
      IDX_EVENT: rd_pins = event_q;
      IDX_BOTH:  rd_pins = both_q;
      IDX_IMSC:  rd_pins = imsc_q;
      IDX_RIS:   rd_pins = ris;
      IDX_MIS:   rd_pins = mis;
      default: ;
    endcase
  end

  assign rd_word = id_hit ? DATA_WIDTH'(ID_VALUE) : DATA_WIDTH'(rd_pins);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q   <= sel_i;
      rdata_q <= (sel_i && !we_i) ? rd_word : '0;
    end
  end

  assign ack_o     = ack_q;
  assign rdata_o   = rdata_q;
  assign irq_o     = irq_q;
  assign gpio_o    = dout_q;
  assign gpio_oe_o = dir_q;

endmodule

// File: doc/as_gpio_ctrl.md
# as_gpio_ctrl

Parametrised GPIO controller with per-pin direction, synchronised inputs and a configurable edge/level interrupt unit, memory-mapped on the core's data bus behind the address decoder. It replaces the fixed 8-pin GPIO with one generalised in pin count, bus width and synchroniser depth, and adds interrupt sensing, masking and write-1-to-clear status. A single combined interrupt line goes to the core.

## Interface
- NR_GPIOS, 8, number of pins, 1..DATA_WIDTH
- DATA_WIDTH, 64, bus data width (= reg_width)
- ADDR_WIDTH, 4, register index width (one index per DATA_WIDTH-wide register)
- SYNC_STAGES, 2, input synchroniser flops, minimum 2
- ID_VALUE, 1, constant returned by the ID register
- clk_i  in  1  single clock
- rst_ni  in  1  asynchronous, active-low reset
- sel_i  in  1  bus access request, held for one cycle per access
- we_i  in  1  1 = write, 0 = read; sampled with sel_i
- addr_i  in  ADDR_WIDTH  register index
- wdata_i  in  DATA_WIDTH  write data
- rdata_o  out  DATA_WIDTH  read data, valid while ack_o = 1
- ack_o  out  1  access complete
- gpio_i  in  NR_GPIOS  asynchronous pad inputs
- gpio_o  out  NR_GPIOS  pad output values
- gpio_oe_o  out  NR_GPIOS  pad output enables, 1 = drive
- irq_o  out  1  combined interrupt, registered

## Operation
- Register map (index: name, access, reset):
  - 0: ID, RO, ID_VALUE
  - 1: DIR, RW, 0; 1 = output
  - 2: DOUT, RW, 0
  - 3: DIN, RO; synchronised pin values
  - 4: SENSE, RW, 0; 0 = edge, 1 = level
  - 5: EVENT, RW, 0; edge: 1 = rising, 0 = falling; level: 1 = high, 0 = low
  - 6: BOTH, RW, 0; 1 = both edges; overrides EVENT, ignored when level
  - 7: IMSC, RW, 0; 1 = interrupt enabled
  - 8: RIS, RO; raw status
  - 9: MIS, RO; RIS & IMSC
  - 10: ICR, WO; write 1 clears edge RIS bit; reads 0
- Only bits [NR_GPIOS-1:0] are implemented. Upper bits read 0, and writes to them are ignored.
- Unmapped indices 11..2^ADDR_WIDTH-1 read 0, ignore writes, and still ack.
- gpio_o = DOUT, gpio_oe_o = DIR. DIN reflects pins regardless of DIR, so output pins read back their pad value.
- Synchroniser: SYNC_STAGES flops per pin, plus one history flop `prev` for edge detection.
- Edge pin: the RIS bit is a sticky flop, set on the detected edge (sync != prev in the selected direction).
  - Write-1 to ICR clears it.
  - An edge in the same cycle as a clear wins: the bit stays 1.
- Level pin: the RIS bit equals the matching synchronised level, combinational from the sync stage. ICR has no effect.
- Switching SENSE or EVENT does not clear RIS. A stale edge bit stays until cleared.
- irq_o = registered OR of MIS.

## Timing
- Reset values:
  - All RW registers, sticky RIS, synchroniser and prev flops = 0.
  - gpio_o = 0, gpio_oe_o = 0 (all inputs), irq_o = 0, ack_o = 0, rdata_o = 0.
- Bus handshake:
  - sel_i in cycle N gives ack_o = 1 in cycle N+1 for exactly one cycle.
  - rdata_o is registered and valid in N+1. It is 0 whenever ack_o = 0.
  - Back-to-back accesses are allowed, one per cycle.
- Write latency: a write in cycle N updates the register at the edge ending N. gpio_o and gpio_oe_o change in N+1.
- Input latency:
  - A pin change settling before edge E shows in DIN after SYNC_STAGES edges.
  - The edge RIS bit sets one edge later.
  - irq_o asserts one edge after that: SYNC_STAGES+2 edges after the pad change.
- Level interrupt: irq_o deasserts one cycle after MIS falls.
- Edge interrupt: irq_o deasserts one cycle after the ICR write takes effect.
- Reset mid-operation: asynchronous assertion forces all outputs to reset values immediately. An in-flight access is dropped without ack.
- Pulses shorter than one clock period may be missed. This is accepted.

## Test plan
- Reset/ID:
  - Assert rst_ni = 0 mid-access -> ack_o, irq_o, gpio_oe_o = 0 immediately.
  - After release, read index 0 -> rdata_o = 1 with ack_o in the next cycle.
  - Read index 12 -> 0.
- Output path: write DIR = 0x0F, DOUT = 0xA5 -> gpio_oe_o = 0x0F and gpio_o = 0xA5 one cycle after each write. Read DOUT -> 0x00000000_000000A5.
- Rising edge (SENSE = 0, EVENT = 0x01, IMSC = 0x01):
  - Drive gpio_i[0] 0->1 -> RIS = 0x1 after 3 edges, irq_o after 4 edges.
  - Write ICR = 0x1 -> irq_o = 0 next cycle.
- Both edges with clear collision (BOTH = 0x02, IMSC = 0x02): toggle gpio_i[1] in the same cycle the ICR clear of bit 1 lands -> RIS[1] stays 1.
- Level low (SENSE = 0x80, EVENT = 0, IMSC = 0x80):
  - Hold gpio_i[7] = 0 -> irq_o = 1; writing ICR has no effect.
  - Drive pin high -> irq_o = 0 within SYNC_STAGES+1 cycles.
- Parametrisation: NR_GPIOS = 32, SYNC_STAGES = 3 -> bits 31:0 work, bits 63:32 read 0, and edge latency to irq_o = 5 edges.
